// File: rtl/ff256_inverse_cosine_transform_seq_if.sv
// Handshake bundle for the GF(2^8) inverse transform: coefficient block in, result block out.
// The slave side is the transform engine; the master side is whoever drives it.
interface ff256_inverse_cosine_transform_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] x_out;

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, x_out
  );

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, x_out
  );
endinterface

// File: rtl/ff256_inverse_cosine_transform_seq.sv
// Sequential 8x8 GF(2^8) matrix-vector transform, one matrix row per clock.
// Optional macro FF256ICT_OVERLAP_EN lets a new block be accepted on the edge that retires the previous one.
`ifndef FF256ICT_MATRIX
`define FF256ICT_MATRIX { \
  64'h01_1D_4C_8E_32_9A_D7_05, \
  64'h1D_01_8E_4C_9A_32_05_D7, \
  64'h4C_8E_01_1D_D7_05_32_9A, \
  64'h8E_4C_1D_01_05_D7_9A_32, \
  64'h32_9A_D7_05_01_1D_4C_8E, \
  64'h9A_32_05_D7_1D_01_8E_4C, \
  64'hD7_05_32_9A_4C_8E_01_1D, \
  64'h05_D7_9A_32_8E_4C_1D_01  }
`endif

module ff256_inverse_cosine_transform_seq #(
  parameter logic [0:7][0:7][7:0] betas = `FF256ICT_MATRIX,
  parameter logic [7:0]           POLY  = 8'h1D
) (
  input  logic clk,
  input  logic reset,
  ff256_inverse_cosine_transform_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  r_q, r_d;
  logic [63:0] x_q, x_d;
  logic [63:0] y_q, y_d;
  logic [7:0]  prod [0:7];
  logic [7:0]  row_sum;
  logic        in_ready_s;
  logic        out_valid_s;

  // Shift-and-add multiply; each doubling of the multiplicand folds x^8 back in via POLY.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY : 8'h00);
    end
    return acc;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mul
      assign prod[gi] = gf_mul(betas[r_q][gi], x_q[8*gi +: 8]);
    end
  endgenerate

  always_comb begin
    row_sum = 8'h00;
    for (int k = 0; k < 8; k++) row_sum = row_sum ^ prod[k];
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    x_d         = x_q;
    y_d         = y_q;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          x_d     = bus.x_in;
          r_d     = 3'd0;
          y_d     = 64'h0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        y_d[{r_q, 3'b000} +: 8] = row_sum;
        r_d = r_q + 3'd1;
        if (r_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        out_valid_s = 1'b1;
`ifdef FF256ICT_OVERLAP_EN
        in_ready_s = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            x_d     = bus.x_in;
            r_d     = 3'd0;
            y_d     = 64'h0;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
`else
        if (bus.out_ready) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= 3'd0;
      x_q     <= 64'h0;
      y_q     <= 64'h0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.x_out     = y_q;

endmodule

// File: tb/tb_ff256_inverse_cosine_transform_seq.sv
// Self-checking bench: fixed-vector DUTs (identity, all-ones, reduction) plus a randomized main DUT
// checked against a log/antilog-table GF(2^8) reference model.
module tb_ff256_inverse_cosine_transform_seq;

  localparam logic [0:7][0:7][7:0] M_MAIN = {
    64'h3A_07_C1_55_E2_90_1B_6F, 64'h84_F3_2D_09_77_A6_4E_D1,
    64'h10_BB_68_E5_03_5C_9F_22, 64'hC8_41_F0_1E_AD_36_87_7B,
    64'h5D_92_0C_E9_64_FF_21_B0, 64'h08_6A_D3_47_B5_19_CE_80,
    64'hE1_2F_76_A0_4B_D8_13_95, 64'h99_04_5A_FC_30_C7_62_0D };
  localparam logic [0:7][0:7][7:0] M_ID = {
    64'h0100000000000000, 64'h0001000000000000, 64'h0000010000000000, 64'h0000000100000000,
    64'h0000000001000000, 64'h0000000000010000, 64'h0000000000000100, 64'h0000000000000001 };
  localparam logic [0:7][0:7][7:0] M_ONES = {64{8'h01}};
  localparam logic [0:7][0:7][7:0] M_RED  = {8'h02, 504'h0};
`ifdef FF256ICT_OVERLAP_EN
  localparam int B2B_GAP = 9;
`else
  localparam int B2B_GAP = 10;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [7:0] gf_exp [0:254];
  int         gf_log [0:255];

  always #5 clk = ~clk;

  ff256_inverse_cosine_transform_seq_if bm ();
  ff256_inverse_cosine_transform_seq_if bi ();
  ff256_inverse_cosine_transform_seq_if bo ();
  ff256_inverse_cosine_transform_seq_if br ();

  ff256_inverse_cosine_transform_seq #(.betas(M_MAIN), .POLY(8'h1D)) u_main (.clk(clk), .reset(reset_n), .bus(bm));
  ff256_inverse_cosine_transform_seq #(.betas(M_ID),   .POLY(8'h1D)) u_id   (.clk(clk), .reset(reset_n), .bus(bi));
  ff256_inverse_cosine_transform_seq #(.betas(M_ONES), .POLY(8'h1D)) u_ones (.clk(clk), .reset(reset_n), .bus(bo));
  ff256_inverse_cosine_transform_seq #(.betas(M_RED),  .POLY(8'h1D)) u_red  (.clk(clk), .reset(reset_n), .bus(br));

  // Reference arithmetic: GF(2^8) over x^8+x^4+x^3+x^2+1 via powers of the generator 2.
  task automatic build_tables();
    logic [8:0] v;
    v = 9'h001;
    for (int i = 0; i < 255; i++) begin
      gf_exp[i] = v[7:0];
      gf_log[v[7:0]] = i;
      v = v << 1;
      if (v[8]) v = v ^ 9'h11D;
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gf_exp[(gf_log[a] + gf_log[b]) % 255];
  endfunction

  function automatic logic [63:0] ref_ict(input logic [0:7][0:7][7:0] m, input logic [63:0] x);
    logic [63:0] y;
    logic [7:0]  s;
    y = 64'h0;
    for (int n = 0; n < 8; n++) begin
      s = 8'h00;
      for (int k = 0; k < 8; k++) s = s ^ ref_mul(m[n][k], x[8*k +: 8]);
      y[8*n +: 8] = s;
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one block to the main DUT and wait (bounded) for its result; optional in_valid noise while busy.
  task automatic send_main(input logic [63:0] x, input bit noisy, output int lat);
    bm.x_in = x; bm.in_valid = 1'b1; bm.out_ready = 1'b0;
    tick();
    lat = 0;
    while (!bm.out_valid && lat < 20) begin
      bm.in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bm.x_in = {$urandom, $urandom};
      tick();
      lat++;
    end
    bm.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++; if (bm.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bm.out_valid); end
    n_checks++; if (bm.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bm.in_ready); end
    n_checks++; if (bm.x_out !== 64'h0) begin n_fail++; $display("FAIL reset_x_out: got %h expected 0", bm.x_out); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int n;
    bi.x_in = 64'h0706050403020100; bi.in_valid = 1'b1; bi.out_ready = 1'b0;
    tick();
    bi.in_valid = 1'b0;
    n = 0;
    while (!bi.out_valid && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL identity_latency: got %0d edges expected 8", n); end
    n_checks++; if (bi.x_out !== 64'h0706050403020100) begin n_fail++; $display("FAIL identity_x_out: got %h expected 0706050403020100", bi.x_out); end
    $display("identity block: x_out=%h", bi.x_out);
    bi.out_ready = 1'b1; tick(); bi.out_ready = 1'b0;
    n_checks++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL identity_retire: got out_valid %b expected 0", bi.out_valid); end
  endtask

  task automatic test_all_ones();
    int n;
    bo.x_in = 64'h0807060504030201; bo.in_valid = 1'b1; bo.out_ready = 1'b0;
    tick();
    bo.in_valid = 1'b0;
    n = 0;
    while (!bo.out_valid && n < 20) begin tick(); n++; end
    n_checks++; if (bo.x_out !== 64'h0808080808080808 || !bo.out_valid) begin n_fail++; $display("FAIL ones_x_out: got %h valid %b expected 0808080808080808", bo.x_out, bo.out_valid); end
    $display("all-ones block: x_out=%h", bo.x_out);
    bo.out_ready = 1'b1; tick(); bo.out_ready = 1'b0;
  endtask

  task automatic test_reduction();
    int n;
    br.x_in = 64'h80; br.in_valid = 1'b1; br.out_ready = 1'b0;
    tick();
    br.in_valid = 1'b0;
    n = 0;
    while (!br.out_valid && n < 20) begin tick(); n++; end
    n_checks++; if (br.x_out !== 64'h1D || !br.out_valid) begin n_fail++; $display("FAIL reduction_x_out: got %h valid %b expected 1d", br.x_out, br.out_valid); end
    $display("reduction block: x_out=%h", br.x_out);
    br.out_ready = 1'b1; tick(); br.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] x, exp_y;
    int lat, hold;
    for (int t = 0; t < 8; t++) begin
      x = {$urandom, $urandom};
      exp_y = ref_ict(M_MAIN, x);
      send_main(x, 1'b1, lat);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d edges expected 8", t, lat); end
      n_checks++; if (bm.x_out !== exp_y) begin n_fail++; $display("FAIL random_x_out[%0d]: got %h expected %h", t, bm.x_out, exp_y); end
      $display("random block %0d: x_in=%h x_out=%h", t, x, bm.x_out);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        tick();
        n_checks++; if (bm.x_out !== exp_y) begin n_fail++; $display("FAIL random_hold[%0d]: got %h expected %h", t, bm.x_out, exp_y); end
      end
      bm.out_ready = 1'b1; tick(); bm.out_ready = 1'b0;
      n_checks++; if (bm.out_valid !== 1'b0 || bm.in_ready !== 1'b1) begin n_fail++; $display("FAIL random_retire[%0d]: got valid %b ready %b expected 0 1", t, bm.out_valid, bm.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] x, exp_y;
    int lat;
    x = {$urandom, $urandom};
    exp_y = ref_ict(M_MAIN, x);
    send_main(x, 1'b0, lat);
    n_checks++; if (bm.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_start: got out_valid %b expected 1", bm.out_valid); end
    for (int c = 0; c < 20; c++) begin
      bm.in_valid = 1'($urandom_range(0, 1));
      bm.x_in = {$urandom, $urandom};
      tick();
      n_checks++;
      if (bm.x_out !== exp_y || bm.in_ready !== 1'b0 || bm.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got x_out %h ready %b valid %b expected %h 0 1", c, bm.x_out, bm.in_ready, bm.out_valid, exp_y);
      end
    end
    bm.in_valid = 1'b0;
    $display("backpressure block: x_out=%h held 20 cycles", bm.x_out);
    bm.out_ready = 1'b1; tick(); bm.out_ready = 1'b0;
    n_checks++; if (bm.out_valid !== 1'b0 || bm.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid %b ready %b expected 0 1", bm.out_valid, bm.in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] x, exp_y;
    int lat;
    bm.x_in = {$urandom, $urandom}; bm.in_valid = 1'b1;
    tick();
    bm.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bm.out_valid !== 1'b0 || bm.x_out !== 64'h0 || bm.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: got valid %b x_out %h ready %b expected 0 0 1", bm.out_valid, bm.x_out, bm.in_ready);
    end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (bm.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_partial: got out_valid %b expected 0", bm.out_valid); end
    x = {$urandom, $urandom};
    exp_y = ref_ict(M_MAIN, x);
    send_main(x, 1'b0, lat);
    n_checks++; if (lat !== 8 || bm.x_out !== exp_y) begin n_fail++; $display("FAIL midreset_next: got %0d edges x_out %h expected 8 %h", lat, bm.x_out, exp_y); end
    $display("post-reset block: x_in=%h x_out=%h", x, bm.x_out);
    bm.out_ready = 1'b1; tick(); bm.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q [$];
    int          acc_cyc [$];
    logic [63:0] cur_x, got;
    bit          acc, done;
    int          n_done;
    n_done = 0;
    bm.in_valid = 1'b1; bm.out_ready = 1'b1; bm.x_in = {$urandom, $urandom};
    for (int c = 0; c < 60; c++) begin
      acc = bm.in_ready; cur_x = bm.x_in; done = bm.out_valid; got = bm.x_out;
      tick();
      if (acc) begin
        exp_q.push_back(ref_ict(M_MAIN, cur_x));
        acc_cyc.push_back(cyc);
        bm.x_in = {$urandom, $urandom};
      end
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected: got result %h expected none", got); end
        else begin
          if (got !== exp_q[0]) begin n_fail++; $display("FAIL b2b_x_out[%0d]: got %h expected %h", n_done, got, exp_q[0]); end
          $display("b2b block %0d: x_out=%h", n_done, got);
          void'(exp_q.pop_front());
        end
        n_done++;
      end
    end
    bm.in_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      done = bm.out_valid; got = bm.x_out;
      tick();
      if (done) begin
        n_checks++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL b2b_drain: got %h expected %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    bm.out_ready = 1'b0;
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_outstanding: got %0d blocks left expected 0", exp_q.size()); end
    n_checks++; if (acc_cyc.size() < 5) begin n_fail++; $display("FAIL b2b_accepts: got %0d accepts expected at least 5", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== B2B_GAP) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: got %0d cycles expected %0d", i, acc_cyc[i] - acc_cyc[i-1], B2B_GAP);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bm.in_valid = 1'b0; bm.out_ready = 1'b0; bm.x_in = 64'h0;
    bi.in_valid = 1'b0; bi.out_ready = 1'b0; bi.x_in = 64'h0;
    bo.in_valid = 1'b0; bo.out_ready = 1'b0; bo.x_in = 64'h0;
    br.in_valid = 1'b0; br.out_ready = 1'b0; br.x_in = 64'h0;
    build_tables();
    test_reset();
    test_identity();
    test_all_ones();
    test_reduction();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
